// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcode/funct values, ALU op codes and mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [3:0] ALU_ORI  = 4'b0001;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_ANDI = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_BEQ  = 4'b0110;
  localparam logic [3:0] ALU_R    = 4'b0111;
  localparam logic [3:0] ALU_BNE  = 4'b1000;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MDR   = 2'b01;
  localparam logic [1:0] WD_PC    = 2'b10;

  localparam logic [1:0] SB_REGB  = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_IMM4  = 2'b11;

  localparam logic [1:0] PC_ALU   = 2'b00;
  localparam logic [1:0] PC_OUT   = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_REGA  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       branch_eq;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Moore output decode: maps current state (plus opcode and
// memory handshake in FETCH) to the datapath control word.
module mc_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word per state; unlisted fields stay zero.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SB_IMM4;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = WD_MDR;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_REGB;
        ctrl.alu_op    = ALU_R;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RD;
        ctrl.mem_to_reg = WD_ALU;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_IMM;
        unique case (1'b1)
          opcode == OP_ORI:  ctrl.alu_op = ALU_ORI;
          opcode == OP_LUI:  ctrl.alu_op = ALU_LUI;
          opcode == OP_ANDI: ctrl.alu_op = ALU_ANDI;
          default:           ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RT;
        ctrl.mem_to_reg = WD_ALU;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_REGB;
        ctrl.pc_source = PC_OUT;
        if (opcode == OP_BNE) begin
          ctrl.alu_op    = ALU_BNE;
          ctrl.branch_ne = 1'b1;
        end else begin
          ctrl.alu_op    = ALU_BEQ;
          ctrl.branch_eq = 1'b1;
        end
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_JMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RA;
        ctrl.mem_to_reg = WD_PC;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_REGA;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state
// logic, and reset gating of the decoded control word.
module multi_cycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       branch_eq_o,
  output logic       branch_ne_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic [3:0] state_o
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctrl;
  ctrl_t      ctrl_g;

  // State register; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection, opcode dispatch in DECODE.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:
        state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          opcode_i == OP_LW,
          opcode_i == OP_SW:
            state_d = S_MEM_ADDR;
          opcode_i == OP_RTYPE:
            state_d = (funct_i == FN_JR) ? S_JR : S_R_EXEC;
          opcode_i == OP_ADDI,
          opcode_i == OP_ORI,
          opcode_i == OP_LUI,
          opcode_i == OP_ANDI:
            state_d = S_I_EXEC;
          opcode_i == OP_BEQ,
          opcode_i == OP_BNE:
            state_d = S_BRANCH;
          opcode_i == OP_J:
            state_d = S_JUMP;
          opcode_i == OP_JAL:
            state_d = S_JAL;
          default:
            state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (opcode_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:
        state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EXEC: state_d = S_R_WB;
      S_I_EXEC: state_d = S_I_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_out_decode u_dec (
    .state     (state_q),
    .opcode    (opcode_i),
    .mem_ready (mem_ready_i),
    .ctrl      (ctrl)
  );

  assign ctrl_g  = reset ? '0 : ctrl;
  assign state_o = reset ? 4'd0 : state_q;

  assign pc_write_o   = ctrl_g.pc_write;
  assign branch_eq_o  = ctrl_g.branch_eq;
  assign branch_ne_o  = ctrl_g.branch_ne;
  assign i_or_d_o     = ctrl_g.i_or_d;
  assign mem_read_o   = ctrl_g.mem_read;
  assign mem_write_o  = ctrl_g.mem_write;
  assign ir_write_o   = ctrl_g.ir_write;
  assign reg_dst_o    = ctrl_g.reg_dst;
  assign mem_to_reg_o = ctrl_g.mem_to_reg;
  assign reg_write_o  = ctrl_g.reg_write;
  assign alu_src_a_o  = ctrl_g.alu_src_a;
  assign alu_src_b_o  = ctrl_g.alu_src_b;
  assign alu_op_o     = ctrl_g.alu_op;
  assign pc_source_o  = ctrl_g.pc_source;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-003 opcode_i  in  6  instruction opcode from the datapath IR; stable from DECODE onward.
REQ-004 funct_i  in  6  R-type funct field from the IR.
REQ-005 mem_ready_i  in  1  memory completes the current access this cycle.
REQ-006 pc_write_o  out  1  unconditional PC load.
REQ-007 branch_eq_o / branch_ne_o  out  1 each  conditional PC load, qualified in the datapath by ALU zero / not-zero.
REQ-008 i_or_d_o  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 mem_read_o / mem_write_o  out  1 each  memory strobes.
REQ-010 ir_write_o  out  1  IR load enable.
REQ-011 reg_dst_o  out  2  write-register select: 00=rt, 01=rd, 10=$31.
REQ-012 mem_to_reg_o  out  2  write-data select: 00=ALUOut, 01=MDR, 10=PC.
REQ-013 reg_write_o  out  1  register-file write enable.
REQ-014 alu_src_a_o  out  1  ALU A select: 0=PC, 1=regA.
REQ-015 alu_src_b_o  out  2  ALU B select: 00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-016 alu_op_o  out  4  ALU op; uses the existing single-cycle codes (R=0111, ADD/ADDI/LW/SW=0100, ORI=0001, LUI=0010, ANDI=0011, BEQ=0110, BNE=1000).
REQ-017 pc_source_o  out  2  next-PC select: 00=ALU result, 01=ALUOut, 10=jump target, 11=regA.
REQ-018 state_o  out  4  current state, for debug.

Function
REQ-019 Control SHALL be a Moore FSM with 4-bit state encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11, JR=12, JAL=13.
REQ-020 FETCH SHALL assert mem_read_o, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=0100, pc_source_o=00.
  - Holds in FETCH while mem_ready_i=0.
  - ir_write_o and pc_write_o assert only in the cycle mem_ready_i=1.
  - Then goes to DECODE.
REQ-021 DECODE SHALL compute the branch target (src_a=0, src_b=11, alu_op=0100), then branch on opcode_i:
  - 0x23/0x2B -> MEM_ADDR.
  - 0x00 with funct_i=0x08 -> JR; other 0x00 -> R_EXEC.
  - 0x08/0x0D/0x0F/0x0C -> I_EXEC.
  - 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x03 -> JAL.
  - Any other opcode -> FETCH (executed as a NOP, no writes).
REQ-022 MEM_ADDR: src_a=1, src_b=10, alu_op=0100; goes to MEM_RD for LW, MEM_WR for SW.
REQ-023 MEM_RD: mem_read_o=1, i_or_d_o=1; holds until mem_ready_i=1, then goes to MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01; then FETCH.
REQ-024 MEM_WR: mem_write_o=1, i_or_d_o=1; holds until mem_ready_i=1, then goes to FETCH.
REQ-025 R_EXEC: src_a=1, src_b=00, alu_op=0111; then R_WB.
  - R_WB: reg_write=1, reg_dst=01, mem_to_reg=00; then FETCH.
REQ-026 I_EXEC: src_a=1, src_b=10, alu_op per opcode (REQ-016); then I_WB.
  - I_WB: reg_write=1, reg_dst=00, mem_to_reg=00; then FETCH.
REQ-027 BRANCH: src_a=1, src_b=00, pc_source=01, alu_op=0110 with branch_eq_o=1 for BEQ, or alu_op=1000 with branch_ne_o=1 for BNE; then FETCH.
REQ-028 JUMP: pc_write=1, pc_source=10.
  - JAL: additionally reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4).
  - JR: pc_write=1, pc_source=11.
  - All three then go to FETCH.
REQ-029 Every output not named for a state SHALL be 0 in that state.
REQ-030 Cycles per instruction with mem_ready_i held high SHALL be: LW 5; R, I-ALU and SW 4; BEQ, BNE, J, JAL and JR 3.
  - Each memory wait cycle adds exactly 1 cycle.
REQ-031 Unused state encodings (14, 15) SHALL go to FETCH on the next edge, with all outputs 0.

Reset
REQ-032 While reset=1, state SHALL load FETCH at the clock edge and all outputs SHALL be 0, with reset taking priority over every transition.
REQ-033 Reset asserted mid-instruction SHALL abort the instruction with no reg, mem or PC write after the edge.
  - The first cycle after reset deasserts SHALL be FETCH.

Structure
REQ-034 Package mips_ctrl_pkg SHALL hold:
  - the state encodings;
  - the opcode and funct constants;
  - the alu_op codes;
  - the mux-select codes (reg_dst, mem_to_reg, alu_src_b, pc_source).
REQ-035 The design SHALL be split into:
  - a state register plus next-state logic in multi_cycle_control;
  - one combinational sub-module, mc_ctrl_out_decode (inputs: state, opcode, mem_ready; output: control word).

Verification
REQ-036 reset=1 for 2 cycles, then release -> all outputs 0 during reset; state_o=0 and mem_read_o=1 on the first cycle after release.
REQ-037 LW (opcode 0x23), mem_ready_i=1 -> states 0,1,2,3,4; reg_write_o=1 with mem_to_reg_o=01 in cycle 5 only.
REQ-038 SW (opcode 0x2B), mem_ready_i low for 3 cycles in MEM_WR -> mem_write_o high 4 cycles; 7 cycles total.
REQ-039 BNE (opcode 0x05) -> branch_ne_o=1, alu_op_o=1000, pc_source_o=01 in cycle 3; next state FETCH.
REQ-040 Opcodes 0x00/funct 0x08, 0x03 and 0x3F -> JR (pc_source_o=11), JAL (reg_dst_o=10, mem_to_reg_o=10), NOP (FETCH after DECODE, no writes).
REQ-041 reset=1 asserted in MEM_RD -> no reg_write_o pulse; state_o=0 after the edge.
